prbs_checker: RTL and testbench



---
 rtl/prbs_pkg.sv | 20 ++
 rtl/prbs_checker_if.sv | 27 ++
 rtl/prbs_checker_sat_counter.sv | 26 ++
 rtl/prbs_checker.sv | 165 ++++++++++++++++
 tb/tb_prbs_checker.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker and its companion LFSR generator.
//   prbs_state_e : checker FSM states (SEED, TRACK, LOCKED).
//   prbs_predict : next-bit prediction from history and tap mask. History
//                  is newest-at-bit-0; callers zero-extend to MAX_DEPTH.
package prbs_pkg;

    localparam int MAX_DEPTH = 64;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } prbs_state_e;

    function automatic logic prbs_predict(input logic [MAX_DEPTH-1:0] hist,
                                          input logic [MAX_DEPTH-1:0] coeffs);
        return ^(hist & coeffs);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream and status bundle for prbs_checker.
//   in_valid / in_bit : serial PRBS input, sampled when in_valid=1
//   clear_counts      : synchronous clear of the saturating counters
//   locked / bit_err  : lock status and per-bit error pulse
//   err_count / bit_count : saturating statistics
// master = stimulus/observer side, slave = checker side.
interface prbs_checker_if #(
    parameter int CountWidth = 16
);
    logic                  in_valid;
    logic                  in_bit;
    logic                  clear_counts;
    logic                  locked;
    logic                  bit_err;
    logic [CountWidth-1:0] err_count;
    logic [CountWidth-1:0] bit_count;

    modport master (
        output in_valid, in_bit, clear_counts,
        input  locked, bit_err, err_count, bit_count
    );

    modport slave (
        input  in_valid, in_bit, clear_counts,
        output locked, bit_err, err_count, bit_count
    );
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock and asynchronous active-low reset
//   inc          : add one (holds at all-ones)
//   clr          : zero the count; wins over inc on the same cycle
//   count        : current value
module sat_counter #(
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [CountWidth-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CountWidth'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker.
// Seeds its history from the first Depth received bits, tracks until
// LockCount consecutive predictions match, then runs free on its own
// prediction and counts mismatches. Too many errors inside one Window
// drops it back to SEED.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : in_valid, in_bit, clear_counts in;
//                  locked, bit_err, err_count, bit_count out
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               Depth      = 8,
    parameter logic [Depth-1:0] Coeffs     = Depth'(8'b10111000),
    parameter int               LockCount  = 16,
    parameter int               Window     = 64,
    parameter int               ErrThresh  = 4,
    parameter int               CountWidth = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    prbs_checker_if.slave  bus
);

    localparam int SEED_W = $clog2(Depth + 1);
    localparam int RUN_W  = $clog2(LockCount + 1);
    localparam int WIN_W  = $clog2(Window + 1);
    localparam int WERR_W = $clog2(ErrThresh + 1);

    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(Depth - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LockCount - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(Window - 1);
    localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(ErrThresh - 1);

    prbs_state_e        state_q, state_d;
    logic [Depth-1:0]   hist_q, hist_d;
    logic [SEED_W-1:0]  seed_q, seed_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [WIN_W-1:0]   win_bits_q, win_bits_d;
    logic [WERR_W-1:0]  win_errs_q, win_errs_d;
    logic               bit_err_q, bit_err_d;
    logic               locked_q;
    logic               pred;
    logic               mismatch;
    logic               err_inc;
    logic               bit_inc;

    assign pred     = prbs_predict(MAX_DEPTH'(hist_q), MAX_DEPTH'(Coeffs));
    assign mismatch = bus.in_bit ^ pred;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEED;
            hist_q     <= '0;
            seed_q     <= '0;
            run_q      <= '0;
            win_bits_q <= '0;
            win_errs_q <= '0;
            bit_err_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            seed_q     <= seed_d;
            run_q      <= run_d;
            win_bits_q <= win_bits_d;
            win_errs_q <= win_errs_d;
            bit_err_q  <= bit_err_d;
            // Registered view of the state: lags the entering/leaving
            // update by one clock.
            locked_q   <= (state_q == LOCKED);
        end
    end

    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        seed_d     = seed_q;
        run_d      = run_q;
        win_bits_d = win_bits_q;
        win_errs_d = win_errs_q;
        bit_err_d  = 1'b0;
        err_inc    = 1'b0;
        bit_inc    = 1'b0;

        if (bus.in_valid) begin
            case (state_q)
                SEED: begin
                    hist_d = {hist_q[Depth-2:0], bus.in_bit};
                    if (seed_q == SEED_LAST) begin
                        seed_d  = '0;
                        run_d   = '0;
                        state_d = TRACK;
                    end else begin
                        seed_d = seed_q + SEED_W'(1);
                    end
                end

                TRACK: begin
                    hist_d = {hist_q[Depth-2:0], bus.in_bit};
                    if (mismatch) begin
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        run_d      = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                        state_d    = LOCKED;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                    // An all-zero history predicts zeros forever and would
                    // "lock" onto a dead line; reseed instead.
                    if (hist_d == '0) begin
                        seed_d  = '0;
                        run_d   = '0;
                        state_d = SEED;
                    end
                end

                LOCKED: begin
                    // Feed back our own prediction so a corrupted bit
                    // is counted once and never pollutes the history.
                    hist_d    = {hist_q[Depth-2:0], pred};
                    bit_inc   = 1'b1;
                    err_inc   = mismatch;
                    bit_err_d = mismatch;
                    if (mismatch && (win_errs_q == WERR_LAST)) begin
                        seed_d  = '0;
                        run_d   = '0;
                        state_d = SEED;
                    end else if (win_bits_q == WIN_LAST) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = win_bits_q + WIN_W'(1);
                        win_errs_d = win_errs_q + WERR_W'(mismatch);
                    end
                end

                default: begin
                    state_d = SEED;
                end
            endcase
        end
    end

    sat_counter #(.CountWidth(CountWidth)) u_err_count (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (err_inc),
        .clr     (bus.clear_counts),
        .count   (bus.err_count)
    );

    sat_counter #(.CountWidth(CountWidth)) u_bit_count (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (bit_inc),
        .clr     (bus.clear_counts),
        .count   (bus.bit_count)
    );

    assign bus.locked  = locked_q;
    assign bus.bit_err = bit_err_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    localparam logic [7:0] COEFFS = 8'b10111000;

    typedef struct {
        int n;          // clock cycles to apply
        bit valid;
        bit flip;       // invert the transmitted bit (only meaningful with valid)
        bit clr;
        bit exp_locked;
        bit exp_bit_err;
        int exp_err;
        int exp_bits;
    } vec_t;

    logic clk;
    logic reset_n;
    logic [7:0] gen;
    int   n_applied;
    int   n_miss;
    vec_t vecs[$];

    prbs_checker_if #(.CountWidth(16)) bus ();

    prbs_checker #(
        .Depth      (8),
        .Coeffs     (COEFFS),
        .LockCount  (16),
        .Window     (64),
        .ErrThresh  (4),
        .CountWidth (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle from the current negedge, return at the next negedge.
    task automatic step_raw(input bit v, input bit b, input bit clr);
        bus.in_valid     = v;
        bus.in_bit       = b;
        bus.clear_counts = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle of the reference LFSR stream (advances only when valid).
    task automatic step(input bit v, input bit flip, input bit clr);
        bit b;
        b = 1'b0;
        if (v) begin
            b   = ^(gen & COEFFS);
            gen = {gen[6:0], b};
        end
        step_raw(v, v & (b ^ flip), clr);
    endtask

    task automatic do_reset();
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.clear_counts = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic chk_outputs(input string tag, input bit l, input bit be,
                               input int e, input int bc);
        chk({tag, ".locked"},    int'(bus.locked),    int'(l));
        chk({tag, ".bit_err"},   int'(bus.bit_err),   int'(be));
        chk({tag, ".err_count"}, int'(bus.err_count), e);
        chk({tag, ".bit_count"}, int'(bus.bit_count), bc);
    endtask

    initial begin
        int lock_seen;
        n_applied = 0;
        n_miss    = 0;
        gen       = 8'h01;
        reset_n   = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_bit       = 1'b0;
        bus.clear_counts = 1'b0;

        // Continuous clean stream: seed 8, track 16, locked visible at bit 25.
        // Window 1 = bits 25..88, 2 = 89..152, 3 = 153..216.
        vecs.push_back('{8,  1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{16, 1, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1,  1, 0, 0, 1, 0, 0, 1});
        vecs.push_back('{99, 1, 0, 0, 1, 0, 0, 100});
        // single error at bit 125, next bit clean
        vecs.push_back('{1,  1, 1, 0, 1, 1, 1, 101});
        vecs.push_back('{1,  1, 0, 0, 1, 0, 1, 102});
        vecs.push_back('{26, 1, 0, 0, 1, 0, 1, 128});
        // four errors in window 3 (bits 153,155,157,159)
        vecs.push_back('{1,  1, 1, 0, 1, 1, 2, 129});
        vecs.push_back('{1,  1, 0, 0, 1, 0, 2, 130});
        vecs.push_back('{1,  1, 1, 0, 1, 1, 3, 131});
        vecs.push_back('{1,  1, 0, 0, 1, 0, 3, 132});
        vecs.push_back('{1,  1, 1, 0, 1, 1, 4, 133});
        vecs.push_back('{1,  1, 0, 0, 1, 0, 4, 134});
        vecs.push_back('{1,  1, 1, 0, 1, 1, 5, 135});
        vecs.push_back('{1,  1, 0, 0, 0, 0, 5, 135});
        // relock: 24 clean bits after the 4th error, visible one bit later
        vecs.push_back('{23, 1, 0, 0, 0, 0, 5, 135});
        vecs.push_back('{1,  1, 0, 0, 1, 0, 5, 136});
        // clear on an error cycle, then clear alone
        vecs.push_back('{1,  1, 1, 1, 1, 1, 0, 0});
        vecs.push_back('{1,  1, 0, 0, 1, 0, 0, 1});
        vecs.push_back('{1,  1, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{10, 1, 0, 0, 1, 0, 0, 10});
        // in_valid=0 holds everything and never pulses bit_err
        vecs.push_back('{1,  0, 0, 0, 1, 0, 0, 10});
        vecs.push_back('{1,  1, 1, 0, 1, 1, 1, 11});
        vecs.push_back('{1,  0, 0, 0, 1, 0, 1, 11});

        do_reset();
        chk_outputs("reset", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++)
                step(vecs[i].valid, vecs[i].flip, vecs[i].clr);
            chk_outputs($sformatf("vec%0d", i), vecs[i].exp_locked,
                        vecs[i].exp_bit_err, vecs[i].exp_err, vecs[i].exp_bits);
        end

        // Gapped valid 1,0,1,0: 24th valid bit lands on cycle 47,
        // locked visible after cycle 48.
        do_reset();
        for (int c = 1; c <= 48; c++) begin
            step((c % 2) == 1, 1'b0, 1'b0);
            chk($sformatf("gap.bit_err.c%0d", c), int'(bus.bit_err), 0);
            if (c >= 46)
                chk($sformatf("gap.locked.c%0d", c), int'(bus.locked), (c == 48) ? 1 : 0);
        end
        chk("gap.bit_count", int'(bus.bit_count), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("gap.bit_count_after", int'(bus.bit_count), 1);

        // All-zero line must never lock.
        do_reset();
        lock_seen = 0;
        for (int c = 0; c < 200; c++) begin
            step_raw(1'b1, 1'b0, 1'b0);
            if (bus.locked === 1'b1) lock_seen++;
        end
        chk("zero.lock_seen", lock_seen, 0);
        chk("zero.bit_count", int'(bus.bit_count), 0);
        chk("zero.err_count", int'(bus.err_count), 0);

        // Asynchronous reset between edges while locked with bit_err high.
        do_reset();
        for (int c = 0; c < 30; c++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_outputs("pre_rst", 1, 1, 1, 7);
        #2 reset_n = 1'b0;
        #1;
        chk_outputs("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 25; c++) step(1'b1, 1'b0, 1'b0);
        chk_outputs("post_rst", 1, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
